irq_trap_ctrl: RTL and testbench

//  Core-side receiver of the CLINT interrupt lines (timer/software) plus an external line. Holds the M-mode

---
 rtl/irq_trap_ctrl.sv | 257 +++++++++++++++++++++++++
 tb/tb_irq_trap_ctrl.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_trap_ctrl.sv
// ============================================================================
// irq_trap_ctrl
// ----------------------------------------------------------------------------
// Machine-mode interrupt receiver and trap sequencer. The block registers the
// CLINT timer/software lines and an external line, and holds the M-mode
// interrupt CSRs (mstatus, mie, mip, mtvec, mepc, mcause). At instruction-retire
// boundaries it arbitrates pending and enabled interrupts, redirects fetch to
// the handler, and sequences the mret return back to mepc.
//
// Optional feature macro:
//   VECTORED_MODE_EN  - when defined, mtvec[1:0] is writable and mode 2'b01
//                       dispatches to base + 4*cause_code. When undefined,
//                       mtvec[1:0] reads 0 and every trap goes to the base.
//
// Ports:
//   clk_in                     clock
//   reset_in                   synchronous active-high reset
//   timer_interrupt_req_in     level MTI request
//   software_interrupt_req_in  level MSI request
//   external_interrupt_req_in  level MEI request
//   csr_we_in                  CSR write strobe
//   csr_addr_in[11:0]          CSR address (read and write)
//   csr_wdata_in[31:0]         CSR write data
//   csr_rdata_out[31:0]        combinational CSR read data, 0 when unmapped
//   retire_valid_in            an instruction retires (interrupt boundary)
//   next_pc_in[31:0]           PC following the retiring instruction
//   mret_in                    mret retires this cycle
//   redirect_valid_out         one-cycle fetch redirect / flush (registered)
//   redirect_pc_out[31:0]      redirect target (registered)
//   in_handler_out             high while executing the trap handler
// ============================================================================
module irq_trap_ctrl #(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0100,
    parameter logic        RETURN_MPIE = 1'b1
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        timer_interrupt_req_in,
    input  logic        software_interrupt_req_in,
    input  logic        external_interrupt_req_in,
    input  logic        csr_we_in,
    input  logic [11:0] csr_addr_in,
    input  logic [31:0] csr_wdata_in,
    output logic [31:0] csr_rdata_out,
    input  logic        retire_valid_in,
    input  logic [31:0] next_pc_in,
    input  logic        mret_in,
    output logic        redirect_valid_out,
    output logic [31:0] redirect_pc_out,
    output logic        in_handler_out
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MIE     = 12'h304;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MIP     = 12'h344;

    localparam logic [31:0] MIE_MASK = 32'h0000_0888;

`ifdef VECTORED_MODE_EN
    localparam logic [31:0] MTVEC_MASK = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] MTVEC_MASK = 32'hFFFF_FFFC;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TRAP,
        ST_HANDLER,
        ST_RETURN
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_mstatus_mie;
    logic        r_mstatus_mpie;
    logic [31:0] r_mie;
    logic [31:0] r_mip;
    logic [31:0] r_mtvec;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic        r_redirect_valid;
    logic [31:0] r_redirect_pc;

    logic [31:0] w_pend;
    logic        w_take;
    logic        w_mret;
    logic [3:0]  w_code;
    logic        w_mstatus_mie_next;
    logic        w_mstatus_mpie_next;
    logic [31:0] w_mie_next;
    logic [31:0] w_mtvec_next;
    logic [31:0] w_mepc_next;
    logic [31:0] w_mcause_next;
    logic [31:0] w_handler_pc;
    logic        w_redirect_valid_next;
    logic [31:0] w_redirect_pc_next;
    logic [1:0]  w_unused_pc_bits;

    // mepc is word aligned, so the low PC bits are never stored.
    assign w_unused_pc_bits = next_pc_in[1:0];

    // Interrupt arbitration. A take needs a pending+enabled source, global
    // enable, a retire boundary and the IDLE state; the state gate is what
    // blocks nesting. If take and mret coincide in IDLE, the interrupt wins.
    // Priority is external, then software, then timer.
    always_comb begin
        w_pend = r_mip & r_mie;
        w_take = (w_pend != 32'd0) && r_mstatus_mie && retire_valid_in
                 && (r_state == ST_IDLE);
        w_mret = mret_in && !w_take
                 && ((r_state == ST_IDLE) || (r_state == ST_HANDLER));
        if (w_pend[11]) begin
            w_code = 4'd11;
        end else if (w_pend[3]) begin
            w_code = 4'd3;
        end else begin
            w_code = 4'd7;
        end
    end

    // Next CSR values. The software write lands first, then trap entry or mret
    // overrides the fields it owns. Trap/mret read pre-write register values.
    always_comb begin
        w_mstatus_mie_next  = r_mstatus_mie;
        w_mstatus_mpie_next = r_mstatus_mpie;
        w_mie_next          = r_mie;
        w_mtvec_next        = r_mtvec;
        w_mepc_next         = r_mepc;
        w_mcause_next       = r_mcause;
        if (csr_we_in) begin
            case (csr_addr_in)
                ADDR_MSTATUS: begin
                    w_mstatus_mie_next  = csr_wdata_in[3];
                    w_mstatus_mpie_next = csr_wdata_in[7];
                end
                ADDR_MIE:    w_mie_next    = csr_wdata_in & MIE_MASK;
                ADDR_MTVEC:  w_mtvec_next  = csr_wdata_in & MTVEC_MASK;
                ADDR_MEPC:   w_mepc_next   = {csr_wdata_in[31:2], 2'b00};
                ADDR_MCAUSE: w_mcause_next = csr_wdata_in;
                default:     ;
            endcase
        end
        if (w_take) begin
            w_mepc_next         = {next_pc_in[31:2], 2'b00};
            w_mcause_next       = {1'b1, 27'd0, w_code};
            w_mstatus_mpie_next = r_mstatus_mie;
            w_mstatus_mie_next  = 1'b0;
        end else if (w_mret) begin
            w_mstatus_mie_next  = r_mstatus_mpie;
            w_mstatus_mpie_next = RETURN_MPIE;
        end
    end

    // Handler entry point, taken from the mtvec value that will be live once
    // any same-cycle write has landed.
    always_comb begin
        w_handler_pc = {w_mtvec_next[31:2], 2'b00};
`ifdef VECTORED_MODE_EN
        if (w_mtvec_next[1:0] == 2'b01) begin
            w_handler_pc = {w_mtvec_next[31:2], 2'b00} + {26'd0, w_code, 2'b00};
        end
`endif
    end

    // Next-state logic. The redirect is produced one edge early so that it is
    // a registered output that is high exactly while in TRAP or RETURN.
    always_comb begin
        w_state_next          = r_state;
        w_redirect_valid_next = 1'b0;
        w_redirect_pc_next    = 32'd0;
        case (r_state)
            ST_IDLE: begin
                if (w_take) begin
                    w_state_next = ST_TRAP;
                end else if (w_mret) begin
                    w_state_next = ST_RETURN;
                end
            end
            ST_TRAP:    w_state_next = ST_HANDLER;
            ST_HANDLER: begin
                if (w_mret) begin
                    w_state_next = ST_RETURN;
                end
            end
            ST_RETURN:  w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
        if (w_state_next == ST_TRAP) begin
            w_redirect_valid_next = 1'b1;
            w_redirect_pc_next    = w_handler_pc;
        end else if (w_state_next == ST_RETURN) begin
            w_redirect_valid_next = 1'b1;
            w_redirect_pc_next    = w_mepc_next;
        end
    end

    // State register.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // CSR, request-line and redirect registers. mip is a plain level sample of
    // the request lines; software has to clear the source, not mip.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_mstatus_mie    <= 1'b0;
            r_mstatus_mpie   <= 1'b0;
            r_mie            <= 32'd0;
            r_mip            <= 32'd0;
            r_mtvec          <= RESET_MTVEC & MTVEC_MASK;
            r_mepc           <= 32'd0;
            r_mcause         <= 32'd0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= 32'd0;
        end else begin
            r_mstatus_mie    <= w_mstatus_mie_next;
            r_mstatus_mpie   <= w_mstatus_mpie_next;
            r_mie            <= w_mie_next;
            r_mip            <= {20'd0, external_interrupt_req_in, 3'd0,
                                 timer_interrupt_req_in, 3'd0,
                                 software_interrupt_req_in, 3'd0};
            r_mtvec          <= w_mtvec_next;
            r_mepc           <= w_mepc_next;
            r_mcause         <= w_mcause_next;
            r_redirect_valid <= w_redirect_valid_next;
            r_redirect_pc    <= w_redirect_pc_next;
        end
    end

    // CSR read mux. mstatus.MPP is hardwired to machine mode (2'b11).
    always_comb begin
        csr_rdata_out = 32'd0;
        case (csr_addr_in)
            ADDR_MSTATUS: csr_rdata_out = {19'd0, 2'b11, 3'd0, r_mstatus_mpie,
                                           3'd0, r_mstatus_mie, 3'd0};
            ADDR_MIE:     csr_rdata_out = r_mie;
            ADDR_MTVEC:   csr_rdata_out = r_mtvec;
            ADDR_MEPC:    csr_rdata_out = r_mepc;
            ADDR_MCAUSE:  csr_rdata_out = r_mcause;
            ADDR_MIP:     csr_rdata_out = r_mip;
            default:      csr_rdata_out = 32'd0;
        endcase
    end

    assign redirect_valid_out = r_redirect_valid;
    assign redirect_pc_out    = r_redirect_pc;
    assign in_handler_out     = (r_state == ST_HANDLER);

endmodule

// File: tb/tb_irq_trap_ctrl.sv
// ============================================================================
// tb_irq_trap_ctrl
// ----------------------------------------------------------------------------
// Self-checking bench for irq_trap_ctrl. Driver tasks update a transaction-
// level model of the M-mode trap rules and queue every redirect they expect;
// an independent monitor pops that queue whenever the DUT redirects.
// ============================================================================
module tb_irq_trap_ctrl;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic        timer_interrupt_req_in;
    logic        software_interrupt_req_in;
    logic        external_interrupt_req_in;
    logic        csr_we_in;
    logic [11:0] csr_addr_in;
    logic [31:0] csr_wdata_in;
    logic [31:0] csr_rdata_out;
    logic        retire_valid_in;
    logic [31:0] next_pc_in;
    logic        mret_in;
    logic        redirect_valid_out;
    logic [31:0] redirect_pc_out;
    logic        in_handler_out;

    irq_trap_ctrl dut (
        .clk_in                    (clk_in),
        .reset_in                  (reset_in),
        .timer_interrupt_req_in    (timer_interrupt_req_in),
        .software_interrupt_req_in (software_interrupt_req_in),
        .external_interrupt_req_in (external_interrupt_req_in),
        .csr_we_in                 (csr_we_in),
        .csr_addr_in               (csr_addr_in),
        .csr_wdata_in              (csr_wdata_in),
        .csr_rdata_out             (csr_rdata_out),
        .retire_valid_in           (retire_valid_in),
        .next_pc_in                (next_pc_in),
        .mret_in                   (mret_in),
        .redirect_valid_out        (redirect_valid_out),
        .redirect_pc_out           (redirect_pc_out),
        .in_handler_out            (in_handler_out)
    );

    always #10 clk_in = ~clk_in;

    // Rising-edge count, used to pin the exact redirect cycle.
    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] pc;
        int          cyc;
    } expect_t;

    expect_t expQ[$];
    int checks = 0;
    int errors = 0;

    // Architectural model state.
    bit          mMie;
    bit          mMpie;
    bit          mInHandler;
    logic [31:0] mMieReg;
    logic [31:0] mMtvec;
    logic [31:0] mMepc;
    logic [31:0] mMcause;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] mipModel();
        return (32'(external_interrupt_req_in) << 11) |
               (32'(timer_interrupt_req_in) << 7) |
               (32'(software_interrupt_req_in) << 3);
    endfunction

    function automatic logic [31:0] mstatusModel();
        return 32'h0000_1800 | (32'(mMpie) << 7) | (32'(mMie) << 3);
    endfunction

    function automatic int winnerCode(input logic [31:0] pend);
        if (pend[11]) return 11;
        if (pend[3]) return 3;
        return 7;
    endfunction

    function automatic logic [31:0] handlerModel(input int code);
        logic [31:0] base;
        base = mMtvec & ~32'h3;
`ifdef VECTORED_MODE_EN
        if (mMtvec[1:0] == 2'b01) return base + 32'(4 * code);
`endif
        return base;
    endfunction

    function automatic void modelReset();
        mMie       = 1'b0;
        mMpie      = 1'b0;
        mInHandler = 1'b0;
        mMieReg    = 32'd0;
        mMtvec     = 32'h0000_0100;
        mMepc      = 32'd0;
        mMcause    = 32'd0;
    endfunction

    // Monitor: every redirect must match the oldest queued expectation.
    always @(negedge clk_in) begin
        expect_t e;
        if (redirect_valid_out === 1'b1) begin
            checkOutput("redirect_expected", 32'(redirect_valid_out), 32'(expQ.size() != 0));
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                checkOutput("redirect_pc", redirect_pc_out, e.pc);
                checkOutput("redirect_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic doReset();
        @(negedge clk_in);
        reset_in                  = 1'b1;
        retire_valid_in           = 1'b0;
        mret_in                   = 1'b0;
        csr_we_in                 = 1'b0;
        timer_interrupt_req_in    = 1'b0;
        software_interrupt_req_in = 1'b0;
        external_interrupt_req_in = 1'b0;
        @(negedge clk_in);
        reset_in = 1'b0;
        modelReset();
    endtask

    task automatic setReq(input bit ext, input bit sw, input bit tim);
        @(negedge clk_in);
        external_interrupt_req_in = ext;
        software_interrupt_req_in = sw;
        timer_interrupt_req_in    = tim;
        @(negedge clk_in);
    endtask

    task automatic csrWrite(input logic [11:0] addr, input logic [31:0] data);
        @(negedge clk_in);
        csr_we_in    = 1'b1;
        csr_addr_in  = addr;
        csr_wdata_in = data;
        case (addr)
            CSR_MSTATUS: begin mMie = data[3]; mMpie = data[7]; end
            CSR_MIE:     mMieReg = data & 32'h0000_0888;
`ifdef VECTORED_MODE_EN
            CSR_MTVEC:   mMtvec = data;
`else
            CSR_MTVEC:   mMtvec = data & ~32'h3;
`endif
            CSR_MEPC:    mMepc = data & ~32'h3;
            CSR_MCAUSE:  mMcause = data;
            default:     ;
        endcase
        @(negedge clk_in);
        csr_we_in = 1'b0;
    endtask

    task automatic csrRead(input logic [11:0] addr, input logic [31:0] expected,
                           input string name);
        csr_addr_in = addr;
        #1;
        checkOutput(name, csr_rdata_out, expected);
    endtask

    // One retire and/or mret cycle; the model decides whether a trap or a
    // return follows and queues the redirect, then waits until it settles.
    task automatic applyStimulus(input bit retire, input logic [31:0] npc, input bit mret);
        logic [31:0] pend;
        expect_t     e;
        bit          moved;
        moved = 1'b0;
        @(negedge clk_in);
        retire_valid_in = retire;
        next_pc_in      = npc;
        mret_in         = mret;
        pend = mipModel() & mMieReg;
        if (!mInHandler && retire && mMie && (pend != 32'd0)) begin
            e.pc  = handlerModel(winnerCode(pend));
            e.cyc = cyc + 1;
            expQ.push_back(e);
            mMepc      = npc & ~32'h3;
            mMcause    = 32'h8000_0000 | 32'(winnerCode(pend));
            mMpie      = mMie;
            mMie       = 1'b0;
            mInHandler = 1'b1;
            moved      = 1'b1;
        end else if (mret) begin
            e.pc  = mMepc;
            e.cyc = cyc + 1;
            expQ.push_back(e);
            mMie       = mMpie;
            mMpie      = 1'b1;
            mInHandler = 1'b0;
            moved      = 1'b1;
        end
        @(negedge clk_in);
        retire_valid_in = 1'b0;
        mret_in         = 1'b0;
        if (moved) @(negedge clk_in);
        checkOutput("in_handler", 32'(in_handler_out), 32'(mInHandler));
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c0;
        expect_t e;
        reset_in                  = 1'b1;
        timer_interrupt_req_in    = 1'b0;
        software_interrupt_req_in = 1'b0;
        external_interrupt_req_in = 1'b0;
        csr_we_in                 = 1'b0;
        csr_addr_in               = 12'd0;
        csr_wdata_in              = 32'd0;
        retire_valid_in           = 1'b0;
        next_pc_in                = 32'd0;
        mret_in                   = 1'b0;
        modelReset();
        repeat (2) @(negedge clk_in);
        reset_in = 1'b0;

        // Reset values.
        checkOutput("reset_redirect_valid", 32'(redirect_valid_out), 32'd0);
        checkOutput("reset_redirect_pc", redirect_pc_out, 32'd0);
        checkOutput("reset_in_handler", 32'(in_handler_out), 32'd0);
        csrRead(CSR_MTVEC, 32'h0000_0100, "reset_mtvec");
        csrRead(CSR_MSTATUS, 32'h0000_1800, "reset_mstatus");
        csrRead(CSR_MIE, 32'd0, "reset_mie");
        csrRead(CSR_MEPC, 32'd0, "reset_mepc");

        // Timer trap with request and retire rising together: redirect two
        // cycles after the request appears.
        $display("[TB] timer trap latency");
        csrWrite(CSR_MIE, 32'h80);
        csrWrite(CSR_MSTATUS, 32'h8);
        @(negedge clk_in);
        timer_interrupt_req_in = 1'b1;
        retire_valid_in        = 1'b1;
        next_pc_in             = 32'h200;
        c0 = cyc;
        @(negedge clk_in);
        checkOutput("t1_no_early_redirect", 32'(redirect_valid_out), 32'd0);
        e.pc = 32'h100;
        e.cyc = c0 + 2;
        expQ.push_back(e);
        mMepc = 32'h200; mMcause = 32'h8000_0007; mMpie = 1'b1; mMie = 1'b0; mInHandler = 1'b1;
        @(negedge clk_in);
        retire_valid_in = 1'b0;
        @(negedge clk_in);
        checkOutput("t1_in_handler", 32'(in_handler_out), 32'd1);
        csrRead(CSR_MEPC, 32'h200, "t1_mepc");
        csrRead(CSR_MCAUSE, 32'h8000_0007, "t1_mcause");
        csrRead(CSR_MSTATUS, 32'h0000_1880, "t1_mstatus");

        // mret back to mepc, then re-trap because the timer is still pending.
        $display("[TB] mret and re-trap");
        applyStimulus(1'b0, 32'd0, 1'b1);
        csrRead(CSR_MSTATUS, 32'h0000_1888, "t3_mstatus_after_mret");
        applyStimulus(1'b1, 32'h300, 1'b0);
        csrRead(CSR_MEPC, 32'h300, "t3_mepc_retrap");
        applyStimulus(1'b0, 32'd0, 1'b1);
        setReq(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h400, 1'b0);

        // Priority: external first, then software over timer.
        $display("[TB] priority");
        doReset();
        csrWrite(CSR_MIE, 32'h888);
        csrWrite(CSR_MSTATUS, 32'h8);
        setReq(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'h500, 1'b0);
        csrRead(CSR_MCAUSE, 32'h8000_000B, "t2_mcause_mei");
        setReq(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'd0, 1'b1);
        applyStimulus(1'b1, 32'h600, 1'b0);
        csrRead(CSR_MCAUSE, 32'h8000_0003, "t2_mcause_msi");
        applyStimulus(1'b0, 32'd0, 1'b1);
        setReq(1'b0, 1'b0, 1'b0);

        // Pending and enabled, but global enable or retire missing.
        $display("[TB] blocked interrupts");
        csrWrite(CSR_MIE, 32'h80);
        csrWrite(CSR_MSTATUS, 32'h0);
        setReq(1'b0, 1'b0, 1'b1);
        csrRead(CSR_MIP, 32'h80, "t4_mip");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_in);
            retire_valid_in = 1'b1;
            next_pc_in      = $urandom;
            checkOutput("t4_no_redirect_mie0", 32'(redirect_valid_out), 32'd0);
        end
        @(negedge clk_in);
        retire_valid_in = 1'b0;
        csrWrite(CSR_MSTATUS, 32'h8);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_in);
            checkOutput("t4_no_redirect_noretire", 32'(redirect_valid_out), 32'd0);
        end
        csrRead(CSR_MIP, 32'h80, "t4_mip_still");
        csrWrite(CSR_MIP, 32'h0);
        csrRead(CSR_MIP, 32'h80, "t4_mip_write_ignored");
        applyStimulus(1'b1, 32'h700, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b1);
        setReq(1'b0, 1'b0, 1'b0);

        // mtvec mode bits.
        $display("[TB] mtvec mode");
        doReset();
        csrWrite(CSR_MTVEC, 32'h101);
`ifdef VECTORED_MODE_EN
        csrRead(CSR_MTVEC, 32'h101, "t5_mtvec");
        checkOutput("t5_handler_model", handlerModel(3), 32'h10C);
`else
        csrRead(CSR_MTVEC, 32'h100, "t5_mtvec");
        checkOutput("t5_handler_model", handlerModel(3), 32'h100);
`endif
        csrWrite(CSR_MIE, 32'h8);
        csrWrite(CSR_MSTATUS, 32'h8);
        setReq(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h800, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b1);
        setReq(1'b0, 1'b0, 1'b0);

        // Reset during TRAP, during HANDLER, and on the take edge itself.
        $display("[TB] reset mid-trap");
        doReset();
        csrWrite(CSR_MTVEC, 32'h4000);
        csrWrite(CSR_MIE, 32'h80);
        csrWrite(CSR_MSTATUS, 32'h8);
        setReq(1'b0, 1'b0, 1'b1);
        @(negedge clk_in);
        retire_valid_in = 1'b1;
        next_pc_in      = 32'h900;
        e.pc = 32'h4000;
        e.cyc = cyc + 1;
        expQ.push_back(e);
        @(negedge clk_in);
        retire_valid_in = 1'b0;
        reset_in        = 1'b1;
        @(negedge clk_in);
        reset_in = 1'b0;
        modelReset();
        checkOutput("t6_trap_rst_valid", 32'(redirect_valid_out), 32'd0);
        checkOutput("t6_trap_rst_pc", redirect_pc_out, 32'd0);
        checkOutput("t6_trap_rst_handler", 32'(in_handler_out), 32'd0);
        csrRead(CSR_MTVEC, 32'h100, "t6_trap_rst_mtvec");
        csrRead(CSR_MSTATUS, 32'h1800, "t6_trap_rst_mstatus");
        csrWrite(CSR_MIE, 32'h80);
        csrWrite(CSR_MSTATUS, 32'h8);
        applyStimulus(1'b1, 32'hA00, 1'b0);
        @(negedge clk_in);
        reset_in = 1'b1;
        @(negedge clk_in);
        reset_in = 1'b0;
        modelReset();
        checkOutput("t6_hdl_rst_handler", 32'(in_handler_out), 32'd0);
        checkOutput("t6_hdl_rst_valid", 32'(redirect_valid_out), 32'd0);
        csrRead(CSR_MEPC, 32'd0, "t6_hdl_rst_mepc");
        csrWrite(CSR_MIE, 32'h80);
        csrWrite(CSR_MSTATUS, 32'h8);
        @(negedge clk_in);
        retire_valid_in = 1'b1;
        next_pc_in      = 32'hB00;
        reset_in        = 1'b1;
        @(negedge clk_in);
        retire_valid_in = 1'b0;
        reset_in        = 1'b0;
        modelReset();
        checkOutput("t6_take_rst_valid", 32'(redirect_valid_out), 32'd0);
        checkOutput("t6_take_rst_handler", 32'(in_handler_out), 32'd0);
        setReq(1'b0, 1'b0, 1'b0);

        // Randomized episodes.
        $display("[TB] random episodes");
        for (int ep = 0; ep < 40; ep++) begin
            csrWrite(CSR_MTVEC, ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 3)));
            csrWrite(CSR_MIE, $urandom);
            csrWrite(CSR_MSTATUS, $urandom);
            if ($urandom_range(0, 3) == 0) csrWrite(CSR_MCAUSE, $urandom);
            setReq(1'($urandom), 1'($urandom), 1'($urandom));
            csrRead(CSR_MIP, mipModel(), "rnd_mip");
            csrRead(CSR_MIE, mMieReg, "rnd_mie");
            csrRead(CSR_MTVEC, mMtvec, "rnd_mtvec");
            applyStimulus(1'b1, $urandom, 1'b0);
            csrRead(CSR_MSTATUS, mstatusModel(), "rnd_mstatus_trap");
            csrRead(CSR_MCAUSE, mMcause, "rnd_mcause");
            csrRead(CSR_MEPC, mMepc, "rnd_mepc");
            if (mInHandler) begin
                for (int k = 0; k < $urandom_range(0, 2); k++) begin
                    applyStimulus(1'b1, $urandom, 1'b0);
                end
                if ($urandom_range(0, 2) == 0) csrWrite(CSR_MEPC, $urandom);
                if ($urandom_range(0, 1) == 0) setReq(1'b0, 1'b0, 1'b0);
                applyStimulus(1'b0, 32'd0, 1'b1);
                csrRead(CSR_MSTATUS, mstatusModel(), "rnd_mstatus_ret");
            end
        end

        repeat (3) @(negedge clk_in);
        checkOutput("expect_queue_drained", 32'(expQ.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
